// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types: request/response structs, burst and size encodings,
// and the arbiter state enum.
package cbus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_e;

  typedef enum logic [2:0] {
    SIZE_1B = 3'd0,
    SIZE_2B = 3'd1,
    SIZE_4B = 3'd2,
    SIZE_8B = 3'd3
  } cbus_size_e;

  // len counts beats minus one, so len=0 is a single-beat transfer.
  typedef struct packed {
    logic              valid;
    logic              is_write;
    cbus_size_e        size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    cbus_burst_e       burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest valid index strictly after
// last_grant_i wins, otherwise wraps to the lowest valid index overall.
module rr_pick
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid_i,
  input  logic [IDX_W-1:0]      last_grant_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  any_o
);

  logic [NUM_INPUTS-1:0] upper;
  logic [NUM_INPUTS-1:0] lower;
  logic                  found;

  // Split requests into those after the last grant and the wrapped remainder;
  // scanning upper first then lower gives the rotating priority.
  always_comb begin
    upper = '0;
    lower = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (i > int'(last_grant_i)) begin
        upper[i] = valid_i[i];
      end else begin
        lower[i] = valid_i[i];
      end
    end

    any_o = |valid_i;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && upper[i]) begin
        idx_o = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && lower[i]) begin
        idx_o = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin N:1 cbus arbiter. One IDLE cycle picks a winner, then BUSY
// forwards that requester to the memory bus until ready&&last or abandon.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int               IDX_W    = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [NUM_INPUTS-1:0] req_valid;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  rr_pick #(
    .NUM_INPUTS(NUM_INPUTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .valid_i     (req_valid),
    .last_grant_i(last_grant_q),
    .idx_o       (pick_idx),
    .any_o       (pick_any)
  );

  // last_grant resets to the top index so input 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      sel_q        <= '0;
      last_grant_q <= LAST_IDX;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    oreq         = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '{ready: 1'b0, last: 1'b0, data: oresp.data};
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        oreq          = ireqs[sel_q];
        iresps[sel_q] = oresp;
        // A dropped valid abandons the grant without rotating priority.
        if (!ireqs[sel_q].valid) begin
          state_d = ARB_IDLE;
        end else if (oresp.ready && oresp.last) begin
          state_d      = ARB_IDLE;
          last_grant_d = sel_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a vector table for single reads, grant
// rotation and abandon, plus hand sequences for burst, write and reset.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = 2;
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h4000_0010;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ireqs (ireqs),
    .iresps(iresps),
    .oreq  (oreq),
    .oresp (oresp)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic        rdy;
    logic        lst;
    logic [31:0] rdata;
    logic        eOv;
    logic [31:0] eAddr;
    logic [1:0]  eR0;
    logic [1:0]  eR1;
    logic        d0Chk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic v0, logic v1, logic rdy, logic lst,
                              logic [31:0] rdata, logic eOv, logic [31:0] eAddr,
                              logic [1:0] eR0, logic [1:0] eR1, logic d0Chk);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.lst = lst; v.rdata = rdata;
    v.eOv = eOv; v.eAddr = eAddr; v.eR0 = eR0; v.eR1 = eR1; v.d0Chk = d0Chk;
    return v;
  endfunction

  function automatic cbus_req_t baseReq(logic [31:0] addr, logic valid);
    cbus_req_t r;
    r          = '0;
    r.valid    = valid;
    r.size     = SIZE_8B;
    r.addr     = addr;
    r.burst    = BURST_INCR;
    return r;
  endfunction

  task automatic check(string name, logic [127:0] actual, logic [127:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(vec_t v);
    reset    = v.rst;
    ireqs[0] = baseReq(A0, v.v0);
    ireqs[1] = baseReq(A1, v.v1);
    oresp    = '{ready: v.rdy, last: v.lst, data: 64'(v.rdata)};
  endtask

  task automatic checkOutput(vec_t v, int idx);
    check($sformatf("v%0d oreq.valid", idx), 128'(oreq.valid), 128'(v.eOv));
    check($sformatf("v%0d oreq.addr", idx), 128'(oreq.addr), 128'(v.eAddr));
    check($sformatf("v%0d iresps0 rdy/last", idx),
          128'({iresps[0].ready, iresps[0].last}), 128'(v.eR0));
    check($sformatf("v%0d iresps1 rdy/last", idx),
          128'({iresps[1].ready, iresps[1].last}), 128'(v.eR1));
    if (v.d0Chk)
      check($sformatf("v%0d iresps0 data", idx), 128'(iresps[0].data), 128'(v.rdata));
    if (v.rst)
      check($sformatf("v%0d oreq zero in reset", idx), 128'(oreq), 128'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single read, then data returned on cycle 3 and back to IDLE on cycle 4.
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h1111,      0, 32'h0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, A0,    2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         1, A0,    2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'hDEAD_BEEF, 1, A0,    2'b11, 2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0, 2'b00, 2'b00, 0));
    // Both inputs requesting: grants alternate 0,1,0,1 with an IDLE between.
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h0, 1, A0,    2'b11, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h0, 1, A1,    2'b00, 2'b11, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h0, 1, A0,    2'b11, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h0, 1, A1,    2'b00, 2'b11, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    // Abandon keeps priority: input 0 still wins the following tie.
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, A0,    2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h0, 1, A0,    2'b11, 2'b00, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0, 1, A1,    2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, A1,    2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 2'b00, 2'b00, 0));

    reset    = 1'b1;
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp    = '0;
    cyc();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      cyc();
    end

    // Burst of four beats from input 1 while input 0 waits.
    reset    = 1'b1;
    ireqs[0] = baseReq(A0, 1'b0);
    ireqs[1] = baseReq(A1, 1'b1);
    ireqs[1].len = 8'd3;
    oresp    = '0;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("burst idle oreq.valid", 128'(oreq.valid), 128'(0));
    cyc();
    ireqs[0].valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      oresp = '{ready: 1'b1, last: (b == 3), data: 64'(100 + b)};
      @(negedge clk);
      check($sformatf("burst b%0d oreq.valid", b), 128'(oreq.valid), 128'(1));
      check($sformatf("burst b%0d oreq.addr", b), 128'(oreq.addr), 128'(A1));
      check($sformatf("burst b%0d oreq.len", b), 128'(oreq.len), 128'(3));
      check($sformatf("burst b%0d oreq.burst", b), 128'(oreq.burst), 128'(BURST_INCR));
      check($sformatf("burst b%0d iresps1 ready", b), 128'(iresps[1].ready), 128'(1));
      check($sformatf("burst b%0d iresps1 last", b), 128'(iresps[1].last), 128'(b == 3));
      check($sformatf("burst b%0d iresps1 data", b), 128'(iresps[1].data), 128'(100 + b));
      check($sformatf("burst b%0d iresps0 ready", b), 128'(iresps[0].ready), 128'(0));
      cyc();
    end
    ireqs[1].valid = 1'b0;
    oresp = '0;
    @(negedge clk);
    check("burst release oreq.valid", 128'(oreq.valid), 128'(0));
    check("burst release iresps0 ready", 128'(iresps[0].ready), 128'(0));
    cyc();
    @(negedge clk);
    check("burst next grant oreq.valid", 128'(oreq.valid), 128'(1));
    check("burst next grant oreq.addr", 128'(oreq.addr), 128'(A0));
    cyc();

    // Write from input 1: all write fields pass through untouched.
    reset    = 1'b1;
    ireqs[0] = baseReq(A0, 1'b0);
    ireqs[1] = baseReq(A1, 1'b1);
    ireqs[1].is_write = 1'b1;
    ireqs[1].strobe   = 8'hFF;
    ireqs[1].data     = 64'h1234;
    oresp    = '0;
    cyc();
    reset = 1'b0;
    cyc();
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
    @(negedge clk);
    check("write oreq.valid", 128'(oreq.valid), 128'(1));
    check("write oreq.is_write", 128'(oreq.is_write), 128'(1));
    check("write oreq.strobe", 128'(oreq.strobe), 128'(8'hFF));
    check("write oreq.data", 128'(oreq.data), 128'(64'h1234));
    check("write iresps0 ready", 128'(iresps[0].ready), 128'(0));
    check("write iresps1 rdy/last", 128'({iresps[1].ready, iresps[1].last}), 128'(2'b11));
    cyc();

    // Reset lands in the second beat of a len=3 burst from input 0.
    reset    = 1'b1;
    ireqs[0] = baseReq(A0, 1'b1);
    ireqs[0].len = 8'd3;
    ireqs[1] = baseReq(A1, 1'b0);
    oresp    = '0;
    cyc();
    reset = 1'b0;
    cyc();
    oresp = '{ready: 1'b1, last: 1'b0, data: 64'h55};
    @(negedge clk);
    check("rstburst beat1 iresps0 ready", 128'(iresps[0].ready), 128'(1));
    cyc();
    reset = 1'b1;
    #1;
    check("rstburst in reset oreq.valid", 128'(oreq.valid), 128'(0));
    check("rstburst in reset iresps0 rdy/last",
          128'({iresps[0].ready, iresps[0].last}), 128'(2'b00));
    @(posedge clk);
    #1;
    reset = 1'b0;
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h66};
    @(negedge clk);
    check("rstburst after release oreq.valid", 128'(oreq.valid), 128'(0));
    check("rstburst after release iresps0 rdy/last",
          128'({iresps[0].ready, iresps[0].last}), 128'(2'b00));
    cyc();
    @(negedge clk);
    check("rstburst regrant oreq.valid", 128'(oreq.valid), 128'(1));
    check("rstburst regrant oreq.addr", 128'(oreq.addr), 128'(A0));
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, meaning the number of upstream cbus requesters (legal 2..8).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port ireqs  input  cbus_req_t[NUM_INPUTS]  upstream requests (valid, is_write, size, addr, strobe, data, len, burst).
REQ-005 SHALL have port iresps  output  cbus_resp_t[NUM_INPUTS]  per-requester responses (ready, last, data).
REQ-006 SHALL have port oreq  output  cbus_req_t  the single request driven toward the top-level memory bus.
REQ-007 SHALL have port oresp  input  cbus_resp_t  the response from the memory bus.

Function
REQ-008 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-009 In IDLE, SHALL drive oreq to all-zero, and every iresps[i] to ready=0, last=0 and data=oresp.data.
REQ-010 In IDLE with at least one ireqs[i].valid, SHALL register the winner index sel and move to BUSY at the next edge.
REQ-011 Winner selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_INPUTS; lowest index at or after the start wins, wrapping around.
REQ-012 Grant latency SHALL be exactly one cycle: a request first valid in IDLE at cycle N appears on oreq.valid at cycle N+1.
REQ-013 In BUSY, SHALL drive oreq = ireqs[sel] combinationally, including valid.
REQ-014 In BUSY, SHALL drive iresps[sel] = oresp; all other iresps SHALL have ready=0 and last=0.
REQ-015 In BUSY, SHALL return to IDLE at the edge where oresp.ready=1 and oresp.last=1, and SHALL set last_grant=sel on that edge.
REQ-016 After any completion, SHALL spend exactly one IDLE cycle before the next grant.
REQ-017 In BUSY, if ireqs[sel].valid=0, SHALL return to IDLE at the next edge (abandoned transaction) without updating last_grant.
REQ-018 Requests from non-selected inputs arriving during BUSY SHALL be held off (ready=0) and arbitrated in the next IDLE cycle.
REQ-019 Multi-beat bursts (len>0) SHALL remain granted until the beat with last=1; ready without last SHALL NOT end the grant.
REQ-020 Upstream requesters SHALL keep valid and request fields stable until they see ready&&last; the arbiter relies on this and does not latch request fields.

Reset
REQ-021 On reset assertion, state SHALL become IDLE asynchronously, sel=0, and last_grant=NUM_INPUTS-1, so input 0 has first priority.
REQ-022 While reset is asserted, oreq SHALL be all-zero and every iresps[i] SHALL have ready=0 and last=0.
REQ-023 Reset asserted mid-burst SHALL abandon the transaction without any further ready or last reaching the requester.

Structure
REQ-024 cbus_req_t, cbus_resp_t, the burst/size/len encodings and the state enum SHALL live in the shared common package.
REQ-025 SHALL contain one sub-module, rr_pick, a combinational round-robin index selector (inputs: valid vector, last_grant; output: winner index, any).
REQ-026 SHALL sit directly upstream of the top-level bus adapter; its oreq/oresp connect unmodified to that adapter.

Verification
REQ-027 Single read: ireqs[0] valid, addr=0x8000_0000, len=0; memory returns ready=1, last=1, data=0xDEAD_BEEF at cycle 3 -> oreq.valid is first high at cycle 1; iresps[0] sees that data with ready=1, last=1 at cycle 3; IDLE at cycle 4.
REQ-028 Simultaneous requests from inputs 0 and 1 after reset -> grant order 0, 1, 0, 1 across four back-to-back transactions, with one IDLE cycle between each.
REQ-029 Burst: input 1, len=3, burst=INCR; memory gives four ready beats with last on the fourth -> grant held for all four, then released; input 0 held at ready=0 throughout.
REQ-030 Write: input 1, is_write=1, strobe=0xFF, data=0x1234 -> oreq mirrors strobe, data and is_write exactly; iresps[0].ready stays 0.
REQ-031 Reset pulse in the second beat of a len=3 burst -> oreq.valid=0 immediately; after release, a fresh request from input 0 is granted within 1 cycle.
REQ-032 Abandon: input 0 drops valid while in BUSY -> IDLE next cycle; last_grant is unchanged, so input 0 still wins the next tie.
